// File: rtl/round_robin_lock_arbiter.sv
// Round-robin mutual-exclusion lock: one owner at a time, released by the owner's strobe or by an
// optional hold timeout, with direct handover to the next round-robin requester.
module round_robin_lock_arbiter #(
  parameter int unsigned REQUESTERS  = 4,
  parameter int unsigned TIMEOUT     = 0,
  parameter int unsigned INDEX_WIDTH = $clog2(REQUESTERS),
  parameter int unsigned COUNT_WIDTH = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
  input  logic                   clock_i,
  input  logic                   resetn_i,
  input  logic [REQUESTERS-1:0]  acquire_i,
  input  logic [REQUESTERS-1:0]  release_i,
  output logic [REQUESTERS-1:0]  grant_o,
  output logic                   locked_o,
  output logic [INDEX_WIDTH-1:0] owner_o,
  output logic                   timeout_pulse_o
);

  localparam logic [0:0] StIdle   = 1'b0;
  localparam logic [0:0] StLocked = 1'b1;

  localparam int unsigned CountLast = (TIMEOUT > 0) ? TIMEOUT - 1 : 0;

  logic [0:0]             state_q, state_d;
  logic [REQUESTERS-1:0]  grant_q, grant_d;
  logic [INDEX_WIDTH-1:0] owner_q, owner_d;
  logic [INDEX_WIDTH-1:0] ptr_q, ptr_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic                   pulse_q, pulse_d;

  logic [REQUESTERS-1:0]  eligible;
  logic [INDEX_WIDTH:0]   idx;
  logic [INDEX_WIDTH-1:0] win;
  logic                   win_valid;
  logic                   free;

  // The current owner never competes for its own handover.
  always_comb begin
    eligible = acquire_i;
    if (state_q == StLocked) begin
      eligible = acquire_i & ~(REQUESTERS'(1) << owner_q);
    end
  end

  always_comb begin
    win_valid = 1'b0;
    win       = '0;
    idx       = '0;
    for (int unsigned i = 0; i < REQUESTERS; i++) begin
      idx = {1'b0, ptr_q} + (INDEX_WIDTH + 1)'(i);
      if (idx >= (INDEX_WIDTH + 1)'(REQUESTERS)) begin
        idx = idx - (INDEX_WIDTH + 1)'(REQUESTERS);
      end
      if (!win_valid && eligible[idx[INDEX_WIDTH-1:0]]) begin
        win_valid = 1'b1;
        win       = idx[INDEX_WIDTH-1:0];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    count_d = count_q;
    pulse_d = 1'b0;
    free    = 1'b0;

    if (state_q == StIdle) begin
      free = 1'b1;
    end else if (release_i[owner_q]) begin
      // Owner release takes precedence over a coincident expiry.
      free = 1'b1;
    end else if (TIMEOUT > 0 && count_q == COUNT_WIDTH'(CountLast)) begin
      free    = 1'b1;
      pulse_d = 1'b1;
    end else if (TIMEOUT > 0) begin
      count_d = count_q + 1'b1;
    end

    if (free) begin
      if (win_valid) begin
        state_d = StLocked;
        grant_d = REQUESTERS'(1) << win;
        owner_d = win;
        ptr_d   = (win == INDEX_WIDTH'(REQUESTERS - 1)) ? '0 : win + 1'b1;
        count_d = '0;
      end else begin
        state_d = StIdle;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= StIdle;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      pulse_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      count_q <= count_d;
      pulse_q <= pulse_d;
    end
  end

  assign grant_o         = grant_q;
  assign locked_o        = (state_q == StLocked);
  assign owner_o         = owner_q;
  assign timeout_pulse_o = pulse_q;

endmodule

// File: tb/tb_round_robin_lock_arbiter.sv
// Scenario tasks plus a randomized run, all checked against a cycle-level ownership model.
module tb_round_robin_lock_arbiter;

  localparam int N  = 4;
  localparam int TO = 5;

  logic       clock_i = 1'b0;
  logic       resetn_i = 1'b0;
  logic [3:0] acquire_i = '0;
  logic [3:0] release_i = '0;
  logic [3:0] grant_o;
  logic       locked_o;
  logic [1:0] owner_o;
  logic       timeout_pulse_o;

  int checks = 0;
  int failures = 0;

  // Model: current owner (-1 when free), last owner shown, next priority index,
  // number of cycles the current grant has been visible, and the forced-release flag.
  int m_owner, m_last, m_ptr, m_held;
  bit m_pulse;

  round_robin_lock_arbiter #(
    .REQUESTERS(N),
    .TIMEOUT   (TO)
  ) dut (
    .clock_i        (clock_i),
    .resetn_i       (resetn_i),
    .acquire_i      (acquire_i),
    .release_i      (release_i),
    .grant_o        (grant_o),
    .locked_o       (locked_o),
    .owner_o        (owner_o),
    .timeout_pulse_o(timeout_pulse_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic void model_reset();
    m_owner = -1;
    m_last  = 0;
    m_ptr   = 0;
    m_held  = 0;
    m_pulse = 0;
  endfunction

  function automatic void model_edge(input logic [3:0] acq, input logic [3:0] rel);
    bit ending;
    int pick;
    ending  = 0;
    pick    = -1;
    m_pulse = 0;
    if (m_owner < 0) ending = 1;
    else if (rel[m_owner]) ending = 1;
    else if (TO > 0 && m_held == TO) begin
      ending  = 1;
      m_pulse = 1;
    end else m_held++;
    if (!ending) return;
    for (int k = 0; k < N; k++) begin
      int cand = (m_ptr + k) % N;
      if (pick < 0 && acq[cand] && cand != m_owner) pick = cand;
    end
    m_owner = pick;
    if (pick >= 0) begin
      m_last = pick;
      m_ptr  = (pick + 1) % N;
      m_held = 1;
    end
  endfunction

  function automatic logic [7:0] exp_vec();
    logic [3:0] g;
    g = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    return {g, m_owner >= 0, 2'(m_last), m_pulse};
  endfunction

  function automatic logic [7:0] dut_vec();
    return {grant_o, locked_o, owner_o, timeout_pulse_o};
  endfunction

  // Called at a falling edge; applies inputs across one rising edge and returns at the next fall.
  task automatic step(input logic [3:0] acq, input logic [3:0] rel);
    acquire_i = acq;
    release_i = rel;
    @(posedge clock_i);
    model_edge(acq, rel);
    @(negedge clock_i);
    release_i = '0;
  endtask

  task automatic test_reset();
    resetn_i  = 1'b0;
    acquire_i = 4'b1111;
    model_reset();
    repeat (2) @(negedge clock_i);
    checks++;
    if (dut_vec() !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs: got %b expected %b", dut_vec(), 8'h00);
    end
    resetn_i = 1'b1;
    step(4'b1111, 4'b0000);
    checks++;
    if (grant_o !== 4'b0001 || owner_o !== 2'd0 || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_first_grant: got %b expected grant 0001 owner 0 (%b)",
               dut_vec(), exp_vec());
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seq [4];
    seq = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < 4; i++) begin
      step(4'b1111, 4'b0000);
      step(4'b1111, 4'b0001 << owner_o);
      checks++;
      if (grant_o !== seq[i] || locked_o !== 1'b1 || dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL rotation_%0d: got grant %b locked %b expected grant %b locked 1",
                 i, grant_o, locked_o, seq[i]);
      end
    end
    step(4'b0000, 4'b0001);
    checks++;
    if (dut_vec() !== exp_vec() || locked_o !== 1'b0) begin
      failures++;
      $display("FAIL rotation_idle: got %b expected %b", dut_vec(), exp_vec());
    end
  endtask

  task automatic test_ignored();
    step(4'b0100, 4'b0000);
    step(4'b0000, 4'b0001);
    checks++;
    if (grant_o !== 4'b0100 || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL ignore_foreign_release: got grant %b expected 0100", grant_o);
    end
    // Owner re-requesting while releasing must not re-win.
    step(4'b0100, 4'b0100);
    checks++;
    if (grant_o !== 4'b0000 || locked_o !== 1'b0 || owner_o !== 2'd2 ||
        dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL owner_release_idle: got %b expected grant 0000 locked 0 owner 2",
               dut_vec());
    end
  endtask

  task automatic test_timeout();
    int high;
    step(4'b0010, 4'b0000);
    high = 0;
    for (int c = 0; c < 8 && grant_o[1] === 1'b1; c++) begin
      high++;
      checks++;
      if (timeout_pulse_o !== 1'b0 || dut_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL timeout_hold_%0d: got %b expected %b", c, dut_vec(), exp_vec());
      end
      step(4'b0000, 4'b0000);
    end
    checks++;
    if (high != TO || timeout_pulse_o !== 1'b1 || grant_o !== 4'b0000) begin
      failures++;
      $display("FAIL timeout_expire: got %0d cycles pulse %b grant %b expected 5 1 0000",
               high, timeout_pulse_o, grant_o);
    end
    step(4'b0000, 4'b0000);
    checks++;
    if (timeout_pulse_o !== 1'b0 || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL timeout_pulse_width: got %b expected %b", dut_vec(), exp_vec());
    end
    step(4'b0010, 4'b0000);
    repeat (TO) step(4'b1000, 4'b0000);
    checks++;
    if (grant_o !== 4'b1000 || timeout_pulse_o !== 1'b1 || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL timeout_handover: got grant %b pulse %b expected 1000 1",
               grant_o, timeout_pulse_o);
    end
    step(4'b0000, 4'b1000);
  endtask

  task automatic test_collision();
    step(4'b0001, 4'b0000);
    repeat (TO - 1) step(4'b0000, 4'b0000);
    step(4'b0000, 4'b0001);
    checks++;
    if (timeout_pulse_o !== 1'b0 || grant_o !== 4'b0000 || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL collision: got pulse %b grant %b expected 0 0000",
               timeout_pulse_o, grant_o);
    end
  endtask

  task automatic test_reset_mid();
    step(4'b1000, 4'b0000);
    repeat (3) step(4'b0000, 4'b0000);
    checks++;
    if (grant_o !== 4'b1000) begin
      failures++;
      $display("FAIL reset_mid_setup: got grant %b expected 1000", grant_o);
    end
    #2 resetn_i = 1'b0;
    #1;
    model_reset();
    checks++;
    if (dut_vec() !== 8'h00) begin
      failures++;
      $display("FAIL reset_mid_async: got %b expected %b", dut_vec(), 8'h00);
    end
    @(negedge clock_i);
    resetn_i = 1'b1;
    step(4'b1111, 4'b0000);
    checks++;
    if (grant_o !== 4'b0001 || dut_vec() !== exp_vec()) begin
      failures++;
      $display("FAIL reset_mid_priority: got grant %b expected 0001", grant_o);
    end
    step(4'b0000, 4'b0001);
  endtask

  task automatic test_random();
    logic [3:0] acq, rel;
    for (int c = 0; c < 2000; c++) begin
      acq = 4'($urandom_range(0, 15));
      rel = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      if (m_owner >= 0 && $urandom_range(0, 3) == 0) rel[m_owner] = 1'b1;
      step(acq, rel);
      checks++;
      if (dut_vec() !== exp_vec() || $countones(grant_o) > 1 || locked_o !== |grant_o) begin
        failures++;
        $display("FAIL random_%0d: got %b expected %b (acq %b rel %b)",
                 c, dut_vec(), exp_vec(), acq, rel);
      end
    end
  endtask

  initial begin
    model_reset();
    @(negedge clock_i);
    test_reset();
    test_rotation();
    test_ignored();
    test_timeout();
    test_collision();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
